// File: rtl/codec_tdm4.sv
// TDM4 codec serial interface: derives BICK/LRCK from the 256*fs clock, shifts four
// W-bit DAC samples out MSB-first and gathers four ADC samples back, one frame per fs.
module codec_tdm4 #(
    parameter int W = 16
) (
    input  logic         clk_256fs,
    input  logic         rst_n,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    output logic         sample_valid,
    output logic         bick,
    output logic         lrck,
    output logic         sdout,
    input  logic         sdin
);

    logic [7:0]   cnt_q, cnt_d;
    logic         bick_q, bick_d;
    logic         lrck_q, lrck_d;
    logic         sdout_q, sdout_d;
    logic         sample_valid_q, sample_valid_d;
    logic [W-1:0] tx_shadow_q [4];
    logic [W-1:0] tx_shadow_d [4];
    logic [W-1:0] sample_out_q [4];
    logic [W-1:0] sample_out_d [4];
    logic [31:0]  rx_shift_q [4];
    logic [31:0]  rx_shift_d [4];

    logic         frame_wrap;
    logic [1:0]   tx_slot, rx_slot;
    logic [4:0]   tx_bit_idx, rx_bit_idx;
    logic [31:0]  tx_word;

    // Slots are handled as 32-bit words left-aligned, so bit k of a slot is word bit 31-k
    // and the unused tail bits fall out as zeros on transmit and are dropped on receive.
    always_comb begin
        cnt_d          = cnt_q + 8'd1;
        frame_wrap     = (cnt_q == 8'hFF);
        bick_d         = cnt_d[0];
        lrck_d         = ~cnt_d[7];
        sample_valid_d = frame_wrap;

        for (int i = 0; i < 4; i++) begin
            tx_shadow_d[i]  = tx_shadow_q[i];
            rx_shift_d[i]   = rx_shift_q[i];
            sample_out_d[i] = sample_out_q[i];
        end

        if (frame_wrap) begin
            tx_shadow_d[0] = sample_in0;
            tx_shadow_d[1] = sample_in1;
            tx_shadow_d[2] = sample_in2;
            tx_shadow_d[3] = sample_in3;
        end

        rx_slot    = cnt_q[7:6];
        rx_bit_idx = cnt_q[5:1];
        if (cnt_q[0]) begin
            rx_shift_d[rx_slot][~rx_bit_idx] = sdin;
        end

        // The last bit of slot 3 lands on the wrap edge itself, so publish the updated words.
        if (frame_wrap) begin
            for (int i = 0; i < 4; i++) begin
                sample_out_d[i] = rx_shift_d[i][31 -: W];
            end
        end

        tx_slot    = cnt_d[7:6];
        tx_bit_idx = cnt_d[5:1];
        tx_word    = 32'(tx_shadow_d[tx_slot]) << (32 - W);
        sdout_d    = sdout_q;
        if (!cnt_d[0]) begin
            sdout_d = tx_word[~tx_bit_idx];
        end
    end

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= 8'd0;
            bick_q         <= 1'b0;
            lrck_q         <= 1'b1;
            sdout_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tx_shadow_q[i]  <= '0;
                rx_shift_q[i]   <= '0;
                sample_out_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            bick_q         <= bick_d;
            lrck_q         <= lrck_d;
            sdout_q        <= sdout_d;
            sample_valid_q <= sample_valid_d;
            for (int i = 0; i < 4; i++) begin
                tx_shadow_q[i]  <= tx_shadow_d[i];
                rx_shift_q[i]   <= rx_shift_d[i];
                sample_out_q[i] <= sample_out_d[i];
            end
        end
    end

    assign bick         = bick_q;
    assign lrck         = lrck_q;
    assign sdout        = sdout_q;
    assign sample_valid = sample_valid_q;
    assign sample_out0  = sample_out_q[0];
    assign sample_out1  = sample_out_q[1];
    assign sample_out2  = sample_out_q[2];
    assign sample_out3  = sample_out_q[3];

endmodule

// File: tb/tb_codec_tdm4.sv
// Self-checking bench for codec_tdm4: per-cycle pin model plus a frame scoreboard
// covering loopback, serial format, external ADC data, mid-frame changes and reset.
module tb_codec_tdm4;

    localparam int W  = 16;
    localparam int IW = $clog2(W);

    logic         clk_256fs = 1'b0;
    logic         rst_n;
    logic [W-1:0] sin [4];
    logic [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic         sample_valid, bick, lrck, sdout, sdin;

    logic         ext_mode = 1'b0;
    logic         ext_req  = 1'b0;
    logic         ext_sdin = 1'b0;
    logic [W-1:0] ext_vals [4];

    logic [7:0]   mcnt;
    logic         mwrapped;
    logic [W-1:0] tx_model [4];

    logic [63:0]  sb_q [$];
    int           checks  = 0;
    int           fails   = 0;
    int           strobes = 0;

    always #5 clk_256fs = ~clk_256fs;

    assign sdin = ext_mode ? ext_sdin : sdout;

    codec_tdm4 #(.W(W)) dut (
        .clk_256fs    (clk_256fs),
        .rst_n        (rst_n),
        .sample_in0   (sin[0]),
        .sample_in1   (sin[1]),
        .sample_in2   (sin[2]),
        .sample_in3   (sin[3]),
        .sample_out0  (sample_out0),
        .sample_out1  (sample_out1),
        .sample_out2  (sample_out2),
        .sample_out3  (sample_out3),
        .sample_valid (sample_valid),
        .bick         (bick),
        .lrck         (lrck),
        .sdout        (sdout),
        .sdin         (sdin)
    );

    // Reference frame counter and transmit shadow, following the codec timing independently.
    always @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            mcnt     <= 8'd0;
            mwrapped <= 1'b0;
            for (int i = 0; i < 4; i++) tx_model[i] <= '0;
        end else begin
            mcnt <= mcnt + 8'd1;
            if (mcnt == 8'hFF) begin
                mwrapped <= 1'b1;
                for (int i = 0; i < 4; i++) tx_model[i] <= sin[i];
            end
        end
    end

    function automatic logic exp_sdout(input logic [7:0] c);
        logic [4:0] k;
        k = c[5:1];
        if (int'(k) >= W) return 1'b0;
        return tx_model[c[7:6]][IW'(W - 1 - int'(k))];
    endfunction

    function automatic logic ext_bit(input logic [7:0] c);
        logic [4:0] k;
        k = c[5:1];
        if (int'(k) >= W) return 1'b1;
        return ext_vals[c[7:6]][IW'(W - 1 - int'(k))];
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One negedge per cycle: check pins against the model, score frames at each strobe.
    task automatic apply_stimulus(input int n);
        logic        exp_valid;
        logic [63:0] exp_frame;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_256fs);
            exp_valid = mwrapped && (mcnt == 8'd0);
            check_output("pins", 64'({bick, lrck, sample_valid, sdout}),
                         64'({mcnt[0], ~mcnt[7], exp_valid, exp_sdout(mcnt)}));
            if (exp_valid) begin
                strobes++;
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $error("[TB] FAIL scoreboard: observed strobe expected queued frame");
                end else begin
                    exp_frame = sb_q.pop_front();
                    check_output("sample_out",
                                 {sample_out3, sample_out2, sample_out1, sample_out0}, exp_frame);
                end
                ext_mode = ext_req;
                if (ext_mode) sb_q.push_back({ext_vals[3], ext_vals[2], ext_vals[1], ext_vals[0]});
                else          sb_q.push_back({sin[3], sin[2], sin[1], sin[0]});
            end
            ext_sdin = ext_bit(mcnt);
        end
    endtask

    task automatic run_to_cnt(input logic [7:0] target);
        int n;
        n = 0;
        do begin
            apply_stimulus(1);
            n++;
        end while (mcnt != target && n < 512);
        check_output("run_to_cnt", 64'(mcnt), 64'(target));
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_pins"}, 64'({bick, lrck, sdout, sample_valid}), 64'(4'b0100));
        check_output({tag, "_out"}, {sample_out3, sample_out2, sample_out1, sample_out0}, 64'd0);
    endtask

    initial begin
        ext_vals[0] = 16'hBEEF;
        ext_vals[1] = 16'h0F0F;
        ext_vals[2] = 16'h1234;
        ext_vals[3] = 16'h00FF;
        for (int i = 0; i < 4; i++) sin[i] = '0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check_reset_state("reset");

        @(negedge clk_256fs);
        sin[0] = 16'h8001;
        sin[1] = 16'h7FFE;
        sin[2] = 16'h0000;
        sin[3] = 16'hA5C3;
        sb_q.push_back(64'd0);
        rst_n = 1'b1;

        apply_stimulus(1024);
        check_output("strobe_count", 64'(strobes), 64'd4);

        sin[0] = 16'h8000;
        sin[1] = '0;
        sin[2] = '0;
        sin[3] = '0;
        apply_stimulus(512);

        sin[1] = 16'h1111;
        run_to_cnt(8'd0);
        run_to_cnt(8'd100);
        sin[1] = 16'h2222;
        apply_stimulus(600);

        ext_req = 1'b1;
        run_to_cnt(8'd0);
        apply_stimulus(300);
        ext_req = 1'b0;
        apply_stimulus(600);

        run_to_cnt(8'd137);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        sb_q.delete();
        sb_q.push_back(64'd0);
        ext_req  = 1'b0;
        ext_mode = 1'b0;
        strobes  = 0;
        repeat (3) @(negedge clk_256fs);
        rst_n = 1'b1;
        apply_stimulus(1024);
        check_output("strobe_count_after_reset", 64'(strobes), 64'd4);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
